// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite types and default widths for the master bridge and the SRAM controller.
package axilite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } master_state_e;

endpackage

// File: rtl/axilite_master_bridge.sv
// Single-outstanding AXI4-Lite master: command/response in, one AXI-Lite transaction out.
// Define AXILITE_MASTER_TIMEOUT_EN to build the per-phase watchdog (rsp_timeout, SLVERR on expiry).
module axilite_master_bridge
    import axilite_pkg::*;
#(
    parameter int ADDR_W         = AXI_ADDR_W,
    parameter int DATA_W         = AXI_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    master_state_e         state_q;
    logic                  cmd_ready_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                  aw_done_q, w_done_q;
    logic                  rsp_valid_q, rsp_write_q;
    logic [ADDR_W-1:0]     awaddr_q, araddr_q;
    logic [DATA_W-1:0]     wdata_q, rsp_rdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [1:0]            rsp_resp_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_done_d, w_done_d;
    logic tmo_fire;

    assign aw_hs     = awvalid_q & m_axi_awready;
    assign w_hs      = wvalid_q  & m_axi_wready;
    assign b_hs      = bready_q  & m_axi_bvalid;
    assign ar_hs     = arvalid_q & m_axi_arready;
    assign r_hs      = rready_q  & m_axi_rvalid;
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q  | w_hs;

`ifdef AXILITE_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             rsp_timeout_q;
    logic             waiting, progress;

    // Any handshake, including the one that changes state, counts as progress.
    assign waiting  = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    assign progress = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign tmo_fire = waiting & ~progress & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (!waiting || progress) tmo_cnt_q <= '0;
            else                      tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_fire)                      rsp_timeout_q <= 1'b1;
            else if (rsp_valid_q && rsp_ready) rsp_timeout_q <= 1'b0;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    // Constant 0; keeps TIMEOUT_CYCLES referenced when the watchdog is not built.
    assign tmo_fire    = (TIMEOUT_CYCLES < 0);
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else if (tmo_fire) begin
            // Abandon the transaction: drops valids mid-handshake by design.
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= SLVERR;
            rsp_rdata_q <= '0;
            state_q     <= RSP;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        rsp_write_q <= cmd_write;
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= WR_RESP;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi_bresp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= m_axi_rdata;
                        rsp_resp_q  <= m_axi_rresp;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axilite_master_bridge.sv
// Scoreboard bench for axilite_master_bridge: a scripted AXI-Lite slave plus a response monitor.
module tb_axilite_master_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_awready = 1'b0;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wvalid, m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0, m_axi_bready;
    logic          m_axi_arvalid, m_axi_arready = 1'b0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic          m_axi_rvalid = 1'b0, m_axi_rready;

    always #5 clock = ~clock;

    axilite_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          tmo;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: sampled just after the falling edge, once stimulus has settled.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_rsp", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("rsp_write", rsp_write, e.write);
                    check_eq("rsp_rdata", rsp_rdata, e.rdata);
                    check_eq("rsp_resp", rsp_resp, e.resp);
                    check_eq("rsp_timeout", rsp_timeout, e.tmo);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: observed stall expected completion");
        $fatal(1, "simulation stalled");
    end

    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
        int c;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        c = 0;
        while (!cmd_ready && c < 50) begin
            @(negedge clock);
            c++;
        end
        if (!cmd_ready) check_eq("cmd_accept_wait", 0, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic slave_write(input int aw_dly, input int w_dly, input logic [1:0] bresp,
                               input logic [AW-1:0] addr);
        int c;
        fork
            begin
                int ca = 0;
                while (!m_axi_awvalid && ca < 50) begin @(negedge clock); ca++; end
                for (int i = 0; i < aw_dly; i++) begin
                    @(negedge clock);
                    check_eq("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, addr});
                    check_eq("bready_early", m_axi_bready, 0);
                end
                m_axi_awready = 1'b1;
                @(negedge clock);
                m_axi_awready = 1'b0;
                check_eq("aw_drop", m_axi_awvalid, 0);
            end
            begin
                int cw = 0;
                while (!m_axi_wvalid && cw < 50) begin @(negedge clock); cw++; end
                repeat (w_dly) @(negedge clock);
                m_axi_wready = 1'b1;
                @(negedge clock);
                m_axi_wready = 1'b0;
                check_eq("w_drop", m_axi_wvalid, 0);
            end
        join
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = bresp;
        c = 0;
        while (!m_axi_bready && c < 50) begin @(negedge clock); c++; end
        if (!m_axi_bready) check_eq("b_wait", 0, 1);
        @(negedge clock);
        m_axi_bvalid = 1'b0;
    endtask

    task automatic slave_read(input int ar_dly, input int r_dly, input logic [DW-1:0] rdata,
                              input logic [1:0] rresp, input logic [AW-1:0] addr);
        int c = 0;
        while (!m_axi_arvalid && c < 50) begin @(negedge clock); c++; end
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clock);
            check_eq("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, addr});
            check_eq("rready_early", m_axi_rready, 0);
        end
        m_axi_arready = 1'b1;
        @(negedge clock);
        m_axi_arready = 1'b0;
        check_eq("ar_drop_rready", {m_axi_arvalid, m_axi_rready}, 2'b01);
        repeat (r_dly) @(negedge clock);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = rdata;
        m_axi_rresp  = rresp;
        c = 0;
        while (!m_axi_rready && c < 50) begin @(negedge clock); c++; end
        @(negedge clock);
        m_axi_rvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while (sb_q.size() != 0 && c < 200) begin @(negedge clock); c++; end
        check_eq("drain", sb_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_write, rsp_timeout, rsp_resp,
                  m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        check_eq({tag, "_data"}, {m_axi_awaddr, m_axi_araddr, m_axi_wstrb}, 0);
        check_eq({tag, "_rdata"}, {m_axi_wdata, rsp_rdata}, 0);
    endtask

    initial begin : stim
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [1:0]    r;
        int            n;

        repeat (3) @(negedge clock);
        check_all_zero("reset");
        rst_n = 1'b1;
        check_eq("ready_at_release", cmd_ready, 0);
        @(negedge clock);
        check_eq("ready_after_release", cmd_ready, 1);

        // Zero-wait write, cycle-exact.
        sb_q.push_back('{1'b1, 32'h0, 2'b00, 1'b0});
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
        cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        @(negedge clock);
        cmd_valid = 1'b0;
        check_eq("zw_awv_wv", {m_axi_awvalid, m_axi_wvalid, cmd_ready}, 3'b110);
        check_eq("zw_awaddr", m_axi_awaddr, 32'h10);
        check_eq("zw_wdata", {m_axi_wdata, m_axi_wstrb}, {32'hDEADBEEF, 4'hF});
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        @(negedge clock);
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        check_eq("zw_bready", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge clock);
        m_axi_bvalid = 1'b0;
        check_eq("zw_rsp_latency", {rsp_valid, m_axi_bready}, 2'b10);
        wait_drain();

        // Skewed write channels.
        sb_q.push_back('{1'b1, 32'h0, 2'b00, 1'b0});
        fork
            send_cmd(1'b1, 32'h24, 32'h12345678, 4'h3);
            slave_write(3, 0, 2'b00, 32'h24);
        join
        wait_drain();

        // Read with wait states and an error response.
        sb_q.push_back('{1'b0, 32'hCAFEF00D, 2'b10, 1'b0});
        fork
            send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
            slave_read(2, 4, 32'hCAFEF00D, 2'b10, 32'h40);
        join
        wait_drain();

        // Response backpressure.
        rsp_ready = 1'b0;
        sb_q.push_back('{1'b0, 32'h0BADC0DE, 2'b11, 1'b0});
        fork
            send_cmd(1'b0, 32'h44, 32'h0, 4'h0);
            slave_read(0, 0, 32'h0BADC0DE, 2'b11, 32'h44);
        join
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold", {rsp_valid, cmd_ready, rsp_resp, rsp_rdata},
                     {1'b1, 1'b0, 2'b11, 32'h0BADC0DE});
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        check_eq("bp_release", {rsp_valid, cmd_ready}, 2'b01);
        wait_drain();

        // Mixed traffic.
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            a = $urandom & 32'h0000_FFFC;
            r = 2'($urandom_range(0, 3));
            if (i[0]) begin
                sb_q.push_back('{1'b1, 32'h0, r, 1'b0});
                fork
                    send_cmd(1'b1, a, d, 4'($urandom_range(0, 15)));
                    slave_write($urandom_range(0, 3), $urandom_range(0, 3), r, a);
                join
            end else begin
                sb_q.push_back('{1'b0, d, r, 1'b0});
                fork
                    send_cmd(1'b0, a, 32'h0, 4'h0);
                    slave_read($urandom_range(0, 3), $urandom_range(0, 3), d, r, a);
                join
            end
            wait_drain();
        end

        // Reset while AW/W are outstanding: no response may follow.
        send_cmd(1'b1, 32'h80, 32'h55AA55AA, 4'hF);
        check_eq("rst_mid_awvalid", m_axi_awvalid, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check_eq("rst_mid_ready", {cmd_ready, m_axi_awvalid, rsp_valid}, 3'b100);
        repeat (10) @(negedge clock);

`ifdef AXILITE_MASTER_TIMEOUT_EN
        // Read whose address phase never completes.
        sb_q.push_back('{1'b0, 32'h0, 2'b10, 1'b1});
        send_cmd(1'b0, 32'h100, 32'h0, 4'h0);
        n = 0;
        while (m_axi_arvalid && n < 100) begin n++; @(negedge clock); end
        check_eq("tmo_cycles", n, TMO);
        check_eq("tmo_rsp", {m_axi_arvalid, rsp_valid, rsp_timeout, rsp_resp}, 5'b01110);
        wait_drain();
`endif

        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
